rcla_sub16_pipe: RTL and testbench
==================================

RCLA_SUB16_PIPE -- requirements
Module: rcla_sub16_pipe

Interface
REQ-001 SHALL have parameter SIGNED_FLAGS, default 1: when 1, ovf reports two's-complement overflow; when 0, ovf is tied to 0.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port a, input, [16:1]: minuend, bit 1 is the LSB.
REQ-005 SHALL have port b, input, [16:1]: subtrahend.
REQ-006 SHALL have port bin, input, 1 bit: borrow-in.
REQ-007 SHALL have port in_valid, input, 1 bit: a, b and bin are valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts an operand set this cycle.
REQ-009 SHALL have port diff, output, [16:1]: a - b - bin modulo 2^16.
REQ-010 SHALL have port bout, output, 1 bit: borrow out of bit 16.
REQ-011 SHALL have port ovf, output, 1 bit: signed overflow.
REQ-012 SHALL have port zero, output, 1 bit: diff == 0.
REQ-013 SHALL have port out_valid, output, 1 bit: diff, bout, ovf and zero are valid.
REQ-014 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.

Function
REQ-015 SHALL transfer an input when in_valid && in_ready on a rising edge, and an output when out_valid && out_ready.
REQ-016 SHALL compute per bit: borrow-generate g[i] = ~a[i] & b[i]; borrow-propagate p[i] = ~(a[i] ^ b[i]); bin enters as the level-0 borrow.
REQ-017 SHALL resolve all borrows with a recursive-doubling (Kogge-Stone) prefix of spans 1, 2, 4 and 8, with no ripple chain.
REQ-018 SHALL compute diff[i] = a[i] ^ b[i] ^ borrow[i-1], where borrow[0] = bin, and set bout = borrow[16].
REQ-019 SHALL compute ovf = (a[16] != b[16]) && (diff[16] != a[16]) when SIGNED_FLAGS = 1.
REQ-020 SHALL use three register stages:
- S1: registers a, b, bin and g/p.
- S2: registers the prefix after spans 1 and 2.
- S3: registers the prefix after spans 4 and 8, plus the final diff, bout, ovf and zero.
REQ-021 SHALL assert out_valid with the result exactly 3 cycles after the accepting edge when there is no backpressure.
REQ-022 SHALL give each stage a valid bit; a stage loads when it is empty or when its contents advance in the same cycle.
REQ-023 SHALL drive in_ready = !S1_valid || S1 advances, combinational from the stage valids and out_ready only, never from in_valid.
REQ-024 SHALL sustain a throughput of one transaction per cycle while out_ready = 1.
REQ-025 SHALL hold diff, bout, ovf, zero and out_valid stable while out_valid && !out_ready.
REQ-026 SHALL hold at most 3 transactions; with all stages full and out_ready = 0, in_ready = 0.
REQ-027 SHALL, when all stages are full and out_ready rises, accept a new input in that same cycle (simultaneous pop and push).
REQ-028 SHALL deliver results in acceptance order with no loss or duplication.
REQ-029 SHALL let data registers of empty stages hold any value; outputs are qualified only by out_valid.

Reset
REQ-030 SHALL, while rst_n = 0 at a rising edge, clear all stage valid bits; from the next cycle out_valid = 0 and in_ready = 1.
REQ-031 SHALL drive diff = 16'h0000, bout = 0, ovf = 0 and zero = 0 after reset.
REQ-032 SHALL discard any in-flight transaction on reset mid-operation and produce no output for it afterwards.

Structure
REQ-033 SHALL place in the shared package: a width constant W = 16, the prefix level count 4, and the stage-count constant 3.
REQ-034 SHALL implement a single sub-module, borrow_prefix_level: one combinational prefix level with span as a parameter, instantiated 4 times.
REQ-035 SHALL use 1-based [16:1] indexing for all operand vectors, consistent with the existing adder.

Verification
REQ-036 SHALL verify basic subtraction: a=16'h0005, b=16'h0003, bin=0 -> 3 cycles later diff=16'h0002, bout=0, ovf=0, zero=0.
REQ-037 SHALL verify the borrow chain: a=16'h0000, b=16'h0001, bin=0 -> diff=16'hFFFF, bout=1, ovf=0, zero=0.
REQ-038 SHALL verify signed overflow and parameter gating:
- a=16'h8000, b=16'h0001 -> diff=16'h7FFF, ovf=1, bout=0.
- Same stimulus with SIGNED_FLAGS=0 -> ovf=0.
REQ-039 SHALL verify zero with borrow-in: a=16'h1234, b=16'h1233, bin=1 -> diff=16'h0000, zero=1, bout=0.
REQ-040 SHALL verify backpressure:
- Stimulus: 5 back-to-back inputs, with out_ready=0 for cycles 3-6.
- Response: in_ready drops once 3 transactions are held, outputs stay stable, and all 5 results emerge in order when out_ready rises.
REQ-041 SHALL verify reset mid-operation: rst_n=0 for 1 cycle with 2 transactions in flight -> next cycle out_valid=0, in_ready=1, diff=16'h0000, and neither result ever appears.

Source files
------------

// File: rtl/rcla_sub16_pipe_pkg.sv
// Shared constants for the pipelined 16-bit Kogge-Stone subtractor.
package rcla_sub16_pipe_pkg;

  localparam int W      = 16;
  localparam int LEVELS = 4;
  localparam int STAGES = 3;

  // Prefix level n combines positions 2**n apart.
  function automatic int span_of(input int level);
    return 1 << level;
  endfunction

endpackage

// File: rtl/rcla_sub16_pipe_borrow_prefix_level.sv
// One combinational Kogge-Stone borrow-prefix level. Positions closer than SPAN
// to the LSB already hold their complete group and pass through unchanged.
module borrow_prefix_level
  import rcla_sub16_pipe_pkg::*;
#(
  parameter int SPAN = 1
) (
  input  logic [W:1] g_i,
  input  logic [W:1] p_i,
  output logic [W:1] g_o,
  output logic [W:1] p_o
);

  for (genvar i = 1; i <= W; i++) begin : g_bit
    if (i > SPAN) begin : g_comb
      assign g_o[i] = g_i[i] | (p_i[i] & g_i[i-SPAN]);
      assign p_o[i] = p_i[i] & p_i[i-SPAN];
    end else begin : g_pass
      assign g_o[i] = g_i[i];
      assign p_o[i] = p_i[i];
    end
  end

endmodule

// File: rtl/rcla_sub16_pipe.sv
// Three-stage pipelined 16-bit subtractor (a - b - bin) with a Kogge-Stone borrow
// prefix and valid/ready flow control on both sides.
module rcla_sub16_pipe
  import rcla_sub16_pipe_pkg::*;
#(
  parameter bit SIGNED_FLAGS = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [W:1] a,
  input  logic [W:1] b,
  input  logic       bin,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [W:1] diff,
  output logic       bout,
  output logic       ovf,
  output logic       zero,
  output logic       out_valid,
  input  logic       out_ready
);

  // Handshake: a transfer happens on a rising edge where valid && ready; ready
  // never depends on the same side's valid, and a full stage loads only when
  // its contents move on in the same cycle.
  logic [STAGES:1] vld_q, vld_d;
  logic            rdy1, rdy2, rdy3;
  logic            ld1, ld2, ld3;

  logic [W:1] a1_q, b1_q, g1_q, p1_q;
  logic       bin1_q;
  logic [W:1] a2_q, b2_q, g2_q, p2_q, g2_d, p2_d;
  logic       bin2_q;
  logic [W:1] diff_q, diff_d;
  logic       bout_q, bout_d, ovf_q, ovf_d, zero_q, zero_d;

  logic [W:1] lvl_gi [LEVELS];
  logic [W:1] lvl_pi [LEVELS];
  logic [W:1] lvl_go [LEVELS];
  logic [W:1] lvl_po [LEVELS];
  logic [W:1] borrow;

  assign rdy3 = !vld_q[3] || out_ready;
  assign rdy2 = !vld_q[2] || rdy3;
  assign rdy1 = !vld_q[1] || rdy2;
  assign ld1  = in_valid && rdy1;
  assign ld2  = vld_q[1] && rdy2;
  assign ld3  = vld_q[2] && rdy3;

  always_comb begin
    vld_d    = vld_q;
    vld_d[1] = rdy1 ? in_valid : vld_q[1];
    vld_d[2] = rdy2 ? vld_q[1] : vld_q[2];
    vld_d[3] = rdy3 ? vld_q[2] : vld_q[3];
  end

  // The first half of the levels feeds S2, the second half reads the S2 registers.
  for (genvar lv = 0; lv < LEVELS; lv++) begin : g_lvl
    if (lv == 0) begin : g_from_s1
      assign lvl_gi[lv] = g1_q;
      assign lvl_pi[lv] = p1_q;
    end else if (lv == LEVELS / 2) begin : g_from_s2
      assign lvl_gi[lv] = g2_q;
      assign lvl_pi[lv] = p2_q;
    end else begin : g_chain
      assign lvl_gi[lv] = lvl_go[lv-1];
      assign lvl_pi[lv] = lvl_po[lv-1];
    end
    borrow_prefix_level #(.SPAN(span_of(lv))) u_lvl (
      .g_i (lvl_gi[lv]),
      .p_i (lvl_pi[lv]),
      .g_o (lvl_go[lv]),
      .p_o (lvl_po[lv])
    );
  end

  assign g2_d = lvl_go[LEVELS/2-1];
  assign p2_d = lvl_po[LEVELS/2-1];

  // bin acts as the borrow into bit 1: it leaves any group that fully propagates.
  always_comb begin
    borrow = lvl_go[LEVELS-1] | (lvl_po[LEVELS-1] & {W{bin2_q}});
    diff_d = a2_q ^ b2_q ^ {borrow[W-1:1], bin2_q};
    bout_d = borrow[W];
    ovf_d  = SIGNED_FLAGS && (a2_q[W] != b2_q[W]) && (diff_d[W] != a2_q[W]);
    zero_d = (diff_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= '0;
      a1_q   <= '0;
      b1_q   <= '0;
      bin1_q <= 1'b0;
      g1_q   <= '0;
      p1_q   <= '0;
      a2_q   <= '0;
      b2_q   <= '0;
      bin2_q <= 1'b0;
      g2_q   <= '0;
      p2_q   <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      if (ld1) begin
        a1_q   <= a;
        b1_q   <= b;
        bin1_q <= bin;
        g1_q   <= ~a & b;
        p1_q   <= ~(a ^ b);
      end
      if (ld2) begin
        a2_q   <= a1_q;
        b2_q   <= b1_q;
        bin2_q <= bin1_q;
        g2_q   <= g2_d;
        p2_q   <= p2_d;
      end
      if (ld3) begin
        diff_q <= diff_d;
        bout_q <= bout_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign in_ready  = rdy1;
  assign out_valid = vld_q[3];
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_rcla_sub16_pipe.sv
// Directed bench for rcla_sub16_pipe: latency, arithmetic corner cases, the
// unsigned-flag variant, backpressure ordering and mid-flight reset.
module tb_rcla_sub16_pipe;
  import rcla_sub16_pipe_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W:1]   a = '0, b = '0;
  logic         bin = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic         in_ready, bout, ovf, zero, out_valid;
  logic [W:1]   diff;
  logic         in_ready_u, bout_u, ovf_u, zero_u, out_valid_u;
  logic [W:1]   diff_u;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  rcla_sub16_pipe #(.SIGNED_FLAGS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .bin(bin), .in_valid(in_valid),
    .in_ready(in_ready), .diff(diff), .bout(bout), .ovf(ovf), .zero(zero),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  rcla_sub16_pipe #(.SIGNED_FLAGS(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .bin(bin), .in_valid(in_valid),
    .in_ready(in_ready_u), .diff(diff_u), .bout(bout_u), .ovf(ovf_u), .zero(zero_u),
    .out_valid(out_valid_u), .out_ready(out_ready)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction with out_ready held high; result due 3 cycles on.
  task automatic run_one(input string tag, input logic [W:1] va, input logic [W:1] vb,
                         input logic vbin, input logic [W:1] ediff, input logic ebout,
                         input logic eovf, input logic ezero);
    a = va; b = vb; bin = vbin; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    check({tag, "_lat1"}, out_valid, 0);
    step();
    check({tag, "_lat2"}, out_valid, 0);
    step();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_diff"}, diff, ediff);
    check({tag, "_bout"}, bout, ebout);
    check({tag, "_ovf"}, ovf, eovf);
    check({tag, "_zero"}, zero, ezero);
    check({tag, "_u_valid"}, out_valid_u, 1);
    check({tag, "_u_in_ready"}, in_ready_u, 1);
    check({tag, "_u_diff"}, diff_u, ediff);
    check({tag, "_u_bout"}, bout_u, ebout);
    check({tag, "_u_zero"}, zero_u, ezero);
    check({tag, "_u_ovf"}, ovf_u, 0);
    step();
    check({tag, "_drained"}, out_valid, 0);
  endtask

  logic [W:1] bp_a   [5] = '{16'h0010, 16'h0100, 16'h1000, 16'hABCD, 16'h0003};
  logic [W:1] bp_b   [5] = '{16'h0001, 16'h0001, 16'h0001, 16'h0BCD, 16'h0005};
  logic       bp_bin [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [W:1] bp_exp [5] = '{16'h000F, 16'h00FF, 16'h0FFE, 16'hA000, 16'hFFFE};

  initial begin
    int sent, got, seen_valid;
    logic [W-1:0] head;

    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_diff", diff, 16'h0000);
    check("rst_bout", bout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_zero", zero, 0);

    run_one("basic",   16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
    run_one("chain",   16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    run_one("sovf",    16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    run_one("zero",    16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
    run_one("bin_all", 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    run_one("povf",    16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
    run_one("ones",    16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);

    // backpressure: out_ready low in cycles 3..6
    sent = 0;
    got  = 0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 6);
      if (sent < 5) begin
        a = bp_a[sent]; b = bp_b[sent]; bin = bp_bin[sent]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc >= 4 && cyc <= 6) begin
        check("bp_full_in_ready", in_ready, 0);
        check("bp_hold_valid", out_valid, 1);
        head = bp_exp[0];
        check("bp_hold_diff", diff, head);
      end
      if (cyc == 7) check("bp_push_pop", in_ready, 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("bp_extra_output", 1, 0);
        else check("bp_order_diff", diff, exp_q.pop_front());
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(bp_exp[sent]);
        sent++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("bp_sent", sent, 5);
    check("bp_received", got, 5);
    out_ready = 1'b1;

    // reset with two transactions in flight
    a = 16'h00FF; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
    step();
    a = 16'h0002; b = 16'h0001;
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_diff", diff, 16'h0000);
    seen_valid = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen_valid++;
      step();
    end
    check("mid_rst_no_ghost", seen_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
